// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of the register file write port between the ALU
// and LSU, plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_NUM_SIZE = 5,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [REG_NUM_SIZE-1:0] iss_rs1,
    input  logic [REG_NUM_SIZE-1:0] iss_rs2,
    input  logic [REG_NUM_SIZE-1:0] iss_rd,
    input  logic                    iss_wr,
    output logic                    iss_stall,
    input  logic                    alu_valid,
    input  logic [REG_NUM_SIZE-1:0] alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    lsu_valid,
    input  logic [REG_NUM_SIZE-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    output logic                    lsu_ready,
    output logic                    rf_we,
    output logic [REG_NUM_SIZE-1:0] rf_wa,
    output logic [XLEN-1:0]         rf_wd,
    output logic [REG_NUM_SIZE:0]   pend_cnt,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    localparam int unsigned NumRegs = 1 << REG_NUM_SIZE;

    logic [NumRegs-1:0]      r_busy;
    logic                    r_last_grant;
    logic                    r_rf_we;
    logic [REG_NUM_SIZE-1:0] r_rf_wa;
    logic [XLEN-1:0]         r_rf_wd;
    logic [REG_NUM_SIZE:0]   r_pend_cnt;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;

    logic                    w_stall;
    logic                    w_accept;
    logic                    w_gnt_alu;
    logic                    w_gnt_lsu;
    logic                    w_wb_grant;
    logic                    w_wb_write;
    logic [REG_NUM_SIZE-1:0] w_wb_rd;
    logic [XLEN-1:0]         w_wb_data;
    logic [NumRegs-1:0]      w_busy_next;
    logic [REG_NUM_SIZE:0]   w_pend_next;

    always_comb begin
        w_stall  = iss_valid & ~rst &
                   (r_busy[iss_rs1] | r_busy[iss_rs2] | (iss_wr & r_busy[iss_rd]));
        w_accept = iss_valid & ~w_stall & iss_wr & (iss_rd != '0);
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_gnt_alu  = ~rst & alu_valid & (~lsu_valid | r_last_grant);
        w_gnt_lsu  = ~rst & lsu_valid & (~alu_valid | ~r_last_grant);
        w_wb_grant = w_gnt_alu | w_gnt_lsu;
        w_wb_rd    = w_gnt_lsu ? lsu_rd : alu_rd;
        w_wb_data  = w_gnt_lsu ? lsu_data : alu_data;
        w_wb_write = w_wb_grant & (w_wb_rd != '0);
    end

    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_write) begin
            w_busy_next[w_wb_rd] = 1'b0;
        end
        if (w_accept) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_comb begin
        w_pend_next = '0;
        for (int i = 0; i < NumRegs; i++) begin
            w_pend_next = w_pend_next + {{REG_NUM_SIZE{1'b0}}, w_busy_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_last_grant <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_wa      <= '0;
            r_rf_wd      <= '0;
            r_pend_cnt   <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_pend_cnt <= w_pend_next;
            r_rf_we    <= w_wb_write;
            if (w_wb_grant) begin
                r_last_grant <= w_gnt_lsu;
            end
            // rf_wa/rf_wd hold when nothing is written so A3/D3 stay quiet.
            if (w_wb_write) begin
                r_rf_wa <= w_wb_rd;
                r_rf_wd <= w_wb_data;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    always_comb begin
        iss_stall = w_stall;
        alu_ready = w_gnt_alu;
        lsu_ready = w_gnt_lsu;
        rf_we     = r_rf_we;
        rf_wa     = r_rf_wa;
        rf_wd     = r_rf_wd;
        pend_cnt  = r_pend_cnt;
        stall_cnt = r_stall_cnt;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the decode-stage register file: it arbitrates the register file's single write port between the ALU and load/store write-back requesters and keeps a per-register busy scoreboard. The scoreboard stalls issue on RAW/WAW hazards. It sits between the execute/memory stages and the register file and drives the register file's WE3/A3/D3 inputs from registered outputs. Those outputs are stable through the register file's negedge capture.

## Interface
- XLEN, 32: data width (`INST_SIZE`).
- REG_NUM_SIZE, 5: register index width; 2^REG_NUM_SIZE registers.
- STALL_CNT_W, 16: width of the stall performance counter.

- clk  in  1  system clock, posedge-triggered.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction this cycle.
- iss_rs1, iss_rs2  in  REG_NUM_SIZE  source registers.
- iss_rd  in  REG_NUM_SIZE  destination register.
- iss_wr  in  1  instruction writes iss_rd.
- iss_stall  out  1  combinational; decode must hold the instruction.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  REG_NUM_SIZE  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  combinational grant to the ALU.
- lsu_valid  in  1  load write-back request.
- lsu_rd  in  REG_NUM_SIZE  load destination.
- lsu_data  in  XLEN  load result.
- lsu_ready  out  1  combinational grant to the LSU.
- rf_we  out  1  registered; drives the register file WE3.
- rf_wa  out  REG_NUM_SIZE  registered; drives A3.
- rf_wd  out  XLEN  registered; drives D3.
- pend_cnt  out  REG_NUM_SIZE+1  registered count of busy registers.
- stall_cnt  out  STALL_CNT_W  registered, saturating count of stalled cycles.

## Operation
- State:
  - busy[2^REG_NUM_SIZE-1:0] scoreboard.
  - last_grant flop (0 = ALU, 1 = LSU).
  - Output registers rf_we/rf_wa/rf_wd.
  - pend_cnt and stall_cnt.
- Register 0 is never marked busy and never written.
- Stall: iss_stall = iss_valid & !rst & (busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])). The WAW check guarantees at most one write in flight per register.
- Issue accept is iss_valid & !iss_stall & iss_wr & (iss_rd != 0). On accept, busy[iss_rd] is set at the next posedge.
- Arbitration, round-robin over two requesters:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant. last_grant updates to the winner on every grant.
  - Neither valid: no grant; last_grant holds.
  - ready is asserted only for the granted requester and is 0 while rst is high.
- A request accepted with rd = 0 is consumed (ready = 1). It produces rf_we = 0 and has no scoreboard effect.
- On a grant with rd != 0:
  - Next posedge: rf_we <= 1, rf_wa <= rd, rf_wd <= data, and busy[rd] is cleared.
  - With no grant, rf_we <= 0 while rf_wa/rf_wd hold.
- Simultaneous clear and set on the same register in one cycle cannot occur, because the WAW stall blocks it. Clear and set on different registers in the same cycle both take effect.
- A write-back to a register that is not busy is still written. The busy bit stays 0.
- pend_cnt <= popcount of the next busy vector.
- stall_cnt increments in every cycle where iss_stall = 1 and saturates at all-ones.
- Reset values:
  - busy = 0, last_grant = 0 (so the LSU wins the first tie).
  - rf_we = 0, rf_wa = 0, rf_wd = 0.
  - pend_cnt = 0, stall_cnt = 0.
  - alu_ready = lsu_ready = iss_stall = 0.
- Reset mid-operation: all in-flight scoreboard state is discarded. Writes granted in the reset cycle are dropped.

## Timing
- Grant in cycle N leads to rf_we/rf_wa/rf_wd valid from the posedge ending N through cycle N+1. The register file captures the write at the negedge of N+1.
- The busy bit clears at the posedge ending N. A stalled dependent instruction therefore issues in N+1 and reads the written value after the negedge. Effective hazard-resolution latency is 1 cycle after the grant.
- Issue accept in cycle M makes busy visible to iss_stall from cycle M+1.
- Handshake: a requester holds valid/rd/data stable until it sees ready = 1 in the same cycle. The transfer completes on that posedge.
- Back-to-back grants are allowed every cycle, giving throughput of one write per cycle.

## Test plan
- Reset, then idle: all outputs 0, and pend_cnt = 0 after 3 cycles.
- Issue rd = 5. A following issue with rs1 = 5 stalls. ALU write-back of rd = 5, data 0xDEADBEEF, is granted in cycle N. Expected: rf_we = 1, rf_wa = 5, rf_wd = 0xDEADBEEF in N+1; the stall drops in N+1; stall_cnt equals the stalled cycles.
- ALU and LSU both valid for 4 cycles with distinct rd: grants run LSU, ALU, LSU, ALU, with rf_we = 1 every cycle.
- Write-back with rd = 0: ready = 1, rf_we = 0, pend_cnt unchanged. Issue with rd = 0 never stalls.
- WAW: issue rd = 7, then a second issue with rd = 7 stalls until the write-back of 7. Separately, a grant clearing 3 and an issue accepting 9 in the same cycle leave pend_cnt unchanged.
- With 2 registers busy, assert rst for 1 cycle mid-stream while the LSU is valid: busy and pend_cnt return to 0, no rf_we pulse, and lsu_ready = 0 during reset.
